onehot_slot_alloc: RTL
======================

Name: onehot_slot_alloc

Overview:
- Parametrised slot allocator built around a generic IDX_W-to-2^IDX_W one-hot decode. Successor to the fixed 2/4/5/6-bit decoders.
- Tracks a busy mask of N = 2^IDX_W slots (MSHR entries, TLB refill ways, ROB/store-buffer tags).
- Grants free slots through a ready/valid handshake and releases them by binary index.
- Supports lowest-first or round-robin search, full flush, and double-free detection.

Parameters:
- IDX_W, 4, index width; derived slot count N = 2^IDX_W, range 1..6.
- POLICY, 0, 0 = lowest-numbered free slot first; 1 = round-robin search starting at last grant + 1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- alloc_req  input  1  requester wants a slot this cycle
- alloc_valid  output  1  at least one slot is free (ready side of handshake)
- alloc_idx  output  IDX_W  binary index of the slot offered this cycle
- alloc_onehot  output  N  one-hot decode of alloc_idx; all zero when alloc_valid=0
- free_valid  input  1  release the slot named by free_idx
- free_idx  input  IDX_W  slot to release
- flush  input  1  release all slots
- busy_mask  output  N  registered busy bit per slot
- free_cnt  output  IDX_W+1  registered count of free slots, 0..N
- err_double_free  output  1  registered one-cycle pulse: free of a non-busy slot

Behaviour:
- Reset (resetn=0, async):
  - busy_mask=0, free_cnt=N, round-robin pointer=0, err_double_free=0.
  - alloc_valid=1, alloc_idx=0, alloc_onehot=1 (follow from the state).
- alloc_valid, alloc_idx and alloc_onehot are combinational from the registered busy_mask and pointer only. They are never a function of alloc_req, free_valid or flush, so there is no comb path from inputs.
- Grant fires when alloc_req && alloc_valid.
  - The offered slot's busy bit is set at the next edge.
  - Zero-cycle offer, one-cycle state update.
  - alloc_req with alloc_valid=0 is ignored and leaves no state change.
- Search, POLICY=0: alloc_idx = lowest i with busy_mask[i]=0.
- Search, POLICY=1: alloc_idx = first free i scanning ptr, ptr+1, ... mod N.
  - On a grant, ptr <= alloc_idx+1 mod N, wrapping N-1 -> 0.
  - ptr is unchanged without a grant.
- Free: free_valid sets busy_mask[free_idx] to 0 at the next edge.
  - A freed slot is not offerable in the same cycle it is freed.
  - It becomes offerable in the following cycle.
- Double free: free_valid with busy_mask[free_idx]=0 at the start of the cycle.
  - err_double_free=1 for the next cycle only.
  - free_cnt is not incremented.
  - The busy mask is unaffected except by a simultaneous grant.
- Simultaneous grant and free of different slots: both apply and free_cnt is unchanged.
- Simultaneous grant and free naming the offered slot: that slot is not busy, so this is a double free.
  - The grant still wins and the slot ends busy.
  - err_double_free pulses and free_cnt decrements by 1.
- free_cnt update rule: free_cnt_next = free_cnt - grant + valid_free, where valid_free = free_valid && busy. It never leaves 0..N.
- Flush has highest priority.
  - Next edge: busy_mask=0, free_cnt=N, ptr=0, err_double_free=0.
  - Any concurrent grant or free is discarded; the requester must not treat it as a grant.
- Invariant: free_cnt == N - popcount(busy_mask) in every cycle.
- Full: alloc_valid=0 and alloc_onehot=0; alloc_idx is don't-care, driven 0.
- IDX_W=1 (N=2) must work. Target is 120-250 lines of RTL.

Test Plan:
- Reset then hold alloc_req=1 for 4 cycles, IDX_W=2, POLICY=0 -> grants idx 0,1,2,3, onehot 0001,0010,0100,1000. Cycle 5: alloc_valid=0, free_cnt=0, busy_mask=1111.
- POLICY=0, full, free idx 2 and keep alloc_req=1 -> grant in the cycle after the free returns idx 2. Same-cycle offer is not allowed.
- POLICY=1, IDX_W=2: grant 0,1, free 0, request again -> grants idx 2 then 3, then wraps to 0. ptr wraps 3->0.
- Free idx 1 while it is not busy -> err_double_free=1 for exactly one cycle; free_cnt and busy_mask unchanged.
- Grant idx 3 with a simultaneous free of busy idx 0 -> busy_mask 0111->1110, free_cnt stays 1.
- Flush with alloc_req and free_valid active when busy_mask=1011 -> next cycle busy_mask=0000, free_cnt=4, alloc_idx=0. Also assert resetn low mid-run -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/onehot_slot_alloc_if.sv
// Handshake bundle between a slot requester/releaser and the slot allocator.
// The allocator reports its busy/free state back over the same bundle.
interface onehot_slot_alloc_if #(
    parameter int IDX_W = 4
);
    localparam int N = 1 << IDX_W;

    logic             alloc_req;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_idx;
    logic [N-1:0]     alloc_onehot;
    logic             free_valid;
    logic [IDX_W-1:0] free_idx;
    logic             flush;
    logic [N-1:0]     busy_mask;
    logic [IDX_W:0]   free_cnt;
    logic             err_double_free;

    modport master (
        output alloc_req, free_valid, free_idx, flush,
        input  alloc_valid, alloc_idx, alloc_onehot, busy_mask, free_cnt, err_double_free
    );

    modport slave (
        input  alloc_req, free_valid, free_idx, flush,
        output alloc_valid, alloc_idx, alloc_onehot, busy_mask, free_cnt, err_double_free
    );
endinterface

// File: rtl/onehot_slot_alloc.sv
// Slot allocator over 2^IDX_W slots: offers a free slot (lowest-first or
// round-robin), releases by index, flushes all, and flags double frees.
module onehot_slot_alloc #(
    parameter int IDX_W  = 4,
    parameter int POLICY = 0
) (
    input logic              clk,
    input logic              resetn,
    onehot_slot_alloc_if.slave bus
);
    localparam int N     = 1 << IDX_W;
    localparam int CNT_W = IDX_W + 1;

    logic [N-1:0]     busy_q;
    logic [N-1:0]     busy_d;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic             grant;
    logic             free_hit;

    // Lowest-first is just a round-robin scan that always starts at slot 0.
    assign start = (POLICY == 1) ? ptr_q : '0;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = start + IDX_W'(k);
            if (!found && !busy_q[pos]) begin
                found = 1'b1;
                pick  = pos;
            end
        end
    end

    assign bus.alloc_valid  = found;
    assign bus.alloc_idx    = pick;
    assign bus.alloc_onehot = found ? (N'(1) << pick) : '0;

    assign grant    = bus.alloc_req && found;
    assign free_hit = bus.free_valid && busy_q[bus.free_idx];

    // Free is applied before grant so a grant of the same slot leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (free_hit) busy_d[bus.free_idx] = 1'b0;
        if (grant)    busy_d[pick]         = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
            cnt_q  <= CNT_W'(N);
            ptr_q  <= '0;
            err_q  <= 1'b0;
        end else if (bus.flush) begin
            busy_q <= '0;
            cnt_q  <= CNT_W'(N);
            ptr_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_q - CNT_W'(grant) + CNT_W'(free_hit);
            ptr_q  <= grant ? pick + 1'b1 : ptr_q;
            err_q  <= bus.free_valid && !busy_q[bus.free_idx];
        end
    end

    assign bus.busy_mask       = busy_q;
    assign bus.free_cnt        = cnt_q;
    assign bus.err_double_free = err_q;
endmodule
